// File: rtl/proc_pkg.sv
// Shared definitions for the instruction dispatcher and the add controller:
// opcodes, operation_type codes, instruction field positions and FSM states.
package proc_pkg;

  localparam logic [5:0] OpcNop  = 6'h00;
  localparam logic [5:0] OpcAddR = 6'h01;
  localparam logic [5:0] OpcAddI = 6'h02;
  localparam logic [5:0] OpcHalt = 6'h3F;

  localparam logic [1:0] OpTypeR = 2'd0;
  localparam logic [1:0] OpTypeI = 2'd1;

  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RdLsb     = 21;
  localparam int unsigned Rs1Lsb    = 16;
  localparam int unsigned Rs2Lsb    = 11;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [1:0] {
    ClsNop,
    ClsAddR,
    ClsAddI,
    ClsHalt
  } op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitDone,
    StHalt
  } disp_state_e;

endpackage

// File: rtl/instruction_dispatcher_if.sv
// Request/response bundle between the dispatcher (master) and the add controller (slave).
interface instruction_dispatcher_if;
  logic        start;
  logic [1:0]  operation_type;
  logic [4:0]  pc;
  logic [4:0]  source_1_address;
  logic [4:0]  source_2_address;
  logic [4:0]  destination_address;
  logic [31:0] source_immediate_value;
  logic        busy;
  logic        done;
  logic        fetch_stage_enable;
  logic [4:0]  next_pc;

  modport master (
    output start, operation_type, pc, source_1_address, source_2_address,
           destination_address, source_immediate_value,
    input  busy, done, fetch_stage_enable, next_pc
  );

  modport slave (
    input  start, operation_type, pc, source_1_address, source_2_address,
           destination_address, source_immediate_value,
    output busy, done, fetch_stage_enable, next_pc
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction field extraction and opcode classification.
module instr_decode
  import proc_pkg::*;
(
  input  logic [31:0] imem_data,
  output op_class_e   op_class,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm32,
  output logic        illegal
);

  logic [5:0] opcode;

  always_comb begin
    opcode   = imem_data[OpcodeLsb +: 6];
    rd       = imem_data[RdLsb +: 5];
    rs1      = imem_data[Rs1Lsb +: 5];
    rs2      = imem_data[Rs2Lsb +: 5];
    imm32    = {imem_data[ImmLsb +: 16], 16'h0000};
    op_class = ClsNop;
    illegal  = 1'b0;
    case (opcode)
      OpcNop:  op_class = ClsNop;
      OpcAddR: op_class = ClsAddR;
      OpcAddI: op_class = ClsAddI;
      OpcHalt: op_class = ClsHalt;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Fetches, decodes and issues instructions to the add controller one at a time,
// with a watchdog on the completion handshake and sticky halt/error status.
module instruction_dispatcher
  import proc_pkg::*;
#(
  parameter logic [4:0]  RESET_PC        = 5'd0,
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic [4:0]                 imem_addr,
  input  logic [31:0]                imem_data,
  instruction_dispatcher_if.master   ctrl,
  output logic                       halted,
  output logic                       error,
  output logic [15:0]                instr_count
);

  localparam int unsigned WdW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);

  disp_state_e    state_q;
  logic [4:0]     pc_q;
  logic           start_q;
  logic [1:0]     op_type_q;
  logic [4:0]     issue_pc_q;
  logic [4:0]     rs1_q, rs2_q, rd_q;
  logic [31:0]    imm_q;
  logic           halted_q, error_q;
  logic [15:0]    count_q;
  logic [WdW-1:0] wdog_q;

  op_class_e   dec_class;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  instr_decode u_decode (
    .imem_data (imem_data),
    .op_class  (dec_class),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .imm32     (dec_imm),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      start_q    <= 1'b0;
      op_type_q  <= OpTypeR;
      issue_pc_q <= RESET_PC;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      wdog_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          state_q <= StDecode;
        end
        StDecode: begin
          op_type_q  <= (dec_class == ClsAddI) ? OpTypeI : OpTypeR;
          issue_pc_q <= pc_q;
          rs1_q      <= dec_rs1;
          rs2_q      <= dec_rs2;
          rd_q       <= dec_rd;
          imm_q      <= dec_imm;
          if (dec_illegal) begin
            error_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            case (dec_class)
              ClsNop: begin
                pc_q    <= pc_q + 5'd1;
                state_q <= StIdle;
              end
              ClsHalt: begin
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end
              default: begin
                start_q <= 1'b1;
                state_q <= StIssue;
              end
            endcase
          end
        end
        StIssue: begin
          // Request is held until the controller acknowledges with busy.
          if (ctrl.busy) begin
            start_q <= 1'b0;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            wdog_q  <= '0;
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (ctrl.fetch_stage_enable) begin
            pc_q    <= ctrl.next_pc;
            state_q <= StIdle;
          end else if (wdog_q == WdLast) begin
            error_q  <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StHalt: begin
          start_q <= 1'b0;
        end
        default: begin
          start_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign imem_addr                   = pc_q;
  assign ctrl.start                  = start_q;
  assign ctrl.operation_type         = op_type_q;
  assign ctrl.pc                     = issue_pc_q;
  assign ctrl.source_1_address       = rs1_q;
  assign ctrl.source_2_address       = rs2_q;
  assign ctrl.destination_address    = rd_q;
  assign ctrl.source_immediate_value = imm_q;
  assign halted                      = halted_q;
  assign error                       = error_q;
  assign instr_count                 = count_q;

endmodule
